// File: rtl/memio_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface memio_access_if #(
  parameter int ADDR_W = 32
);
  logic              Mem_req;
  logic              Mem_we;
  logic [ADDR_W-1:0] Mem_addr;
  logic [31:0]       Mem_wdata;
  logic [31:0]       Mem_rdata;
  logic              Mem_ack;

  modport master (
    output Mem_req, Mem_we, Mem_addr, Mem_wdata,
    input  Mem_rdata, Mem_ack
  );

  modport slave (
    input  Mem_req, Mem_we, Mem_addr, Mem_wdata,
    output Mem_rdata, Mem_ack
  );
endinterface

// File: rtl/memio_access.sv
// Memory-access stage: runs lw/sw over a req/ack bus, stalls the pipeline while busy
// and reports misaligned addresses and ack timeouts with a one-cycle done pulse.
module memio_access #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           Mem_read,
  input  logic           Mem_write,
  input  logic [31:0]    ALU_Result,
  input  logic [31:0]    Read_data_2,
  memio_access_if.master bus,
  output logic [31:0]    Read_data,
  output logic           Mem_stall,
  output logic           Mem_done,
  output logic           Addr_error,
  output logic           Bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              addrErr_q, addrErr_d;
  logic              busErr_q, busErr_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      addrErr_q <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      addrErr_q <= addrErr_d;
      busErr_q  <= busErr_d;
    end
  end

  // Error flags are set only on the transition into DONE so they pulse alongside Mem_done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    addrErr_d = 1'b0;
    busErr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Mem_write || Mem_read) begin
          if (ALU_Result[1:0] != 2'b00) begin
            state_d   = DONE;
            addrErr_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = ADDR_W'(ALU_Result);
            wdata_d = Read_data_2;
            we_d    = Mem_write;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.Mem_ack) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = bus.Mem_rdata;
          end
        end else if ((cnt_q + 8'd1) == TIMEOUT_CNT) begin
          state_d  = DONE;
          busErr_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    Mem_stall = 1'b0;
    case (state_q)
      IDLE:    Mem_stall = Mem_read | Mem_write;
      REQ:     Mem_stall = 1'b1;
      default: Mem_stall = 1'b0;
    endcase
  end

  assign bus.Mem_req   = (state_q == REQ);
  assign bus.Mem_we    = (state_q == REQ) & we_q;
  assign bus.Mem_addr  = addr_q;
  assign bus.Mem_wdata = wdata_q;
  assign Read_data     = rdata_q;
  assign Mem_done      = (state_q == DONE);
  assign Addr_error    = addrErr_q;
  assign Bus_error     = busErr_q;

endmodule

// File: tb/tb_memio_access.sv
// Self-checking bench for memio_access: directed vector table, corner-case sequences
// and randomized transactions scored against a transaction-level model.
module tb_memio_access;

  localparam int TIMEOUT = 4;
  localparam int ADDR_W  = 32;

  logic        clock;
  logic        reset;
  logic        Mem_read;
  logic        Mem_write;
  logic [31:0] ALU_Result;
  logic [31:0] Read_data_2;
  logic [31:0] Read_data;
  logic        Mem_stall;
  logic        Mem_done;
  logic        Addr_error;
  logic        Bus_error;

  memio_access_if #(.ADDR_W(ADDR_W)) bus ();

  memio_access #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .Mem_read   (Mem_read),
    .Mem_write  (Mem_write),
    .ALU_Result (ALU_Result),
    .Read_data_2(Read_data_2),
    .bus        (bus),
    .Read_data  (Read_data),
    .Mem_stall  (Mem_stall),
    .Mem_done   (Mem_done),
    .Addr_error (Addr_error),
    .Bus_error  (Bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelRD;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ackDelay;
    int          expLat;
    int          expReq;
    logic        expWe;
    logic        expAE;
    logic        expBE;
    logic [31:0] expRD;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome follows from alignment, ack cycle and timeout only.
  task automatic modelTxn(input logic wr, input logic [31:0] addr, input logic [31:0] rdata,
                          input int ackDelay, output int lat, output int req,
                          output logic ae, output logic be);
    ae = 1'b0;
    be = 1'b0;
    if (addr[1:0] != 2'b00) begin
      lat = 1; req = 0; ae = 1'b1;
    end else if (ackDelay >= 1 && ackDelay <= TIMEOUT) begin
      lat = ackDelay + 1; req = ackDelay;
      if (!wr) modelRD = rdata;
    end else begin
      lat = TIMEOUT + 1; req = TIMEOUT; be = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int ackDelay,
                               input int expLat, input int expReq, input logic expWe,
                               input logic expAE, input logic expBE, input logic [31:0] expRD);
    int reqCount = 0;
    int doneCyc  = -1;
    @(negedge clock);
    Mem_read    = rd;
    Mem_write   = wr;
    ALU_Result  = addr;
    Read_data_2 = wdata;
    bus.Mem_ack = 1'b0;
    #1;
    checkOutput({tag, ".stallIdle"}, 32'(Mem_stall), 32'd1);
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      @(negedge clock);
      if (bus.Mem_req) begin
        reqCount++;
        checkOutput({tag, ".addr"},  bus.Mem_addr, addr);
        checkOutput({tag, ".wdata"}, bus.Mem_wdata, wdata);
        checkOutput({tag, ".we"},    32'(bus.Mem_we), 32'(expWe));
        checkOutput({tag, ".stallReq"}, 32'(Mem_stall), 32'd1);
      end
      if (Mem_done) begin
        doneCyc = c;
        checkOutput({tag, ".stallDone"}, 32'(Mem_stall), 32'd0);
        checkOutput({tag, ".reqDone"},   32'(bus.Mem_req), 32'd0);
        checkOutput({tag, ".addrErr"},   32'(Addr_error), 32'(expAE));
        checkOutput({tag, ".busErr"},    32'(Bus_error), 32'(expBE));
        break;
      end
      bus.Mem_ack   = (bus.Mem_req && reqCount == ackDelay);
      bus.Mem_rdata = bus.Mem_ack ? rdata : $urandom();
    end
    bus.Mem_ack = 1'b0;
    Mem_read    = 1'b0;
    Mem_write   = 1'b0;
    checkOutput({tag, ".latency"},  32'(doneCyc), 32'(expLat));
    checkOutput({tag, ".reqCount"}, 32'(reqCount), 32'(expReq));
    checkOutput({tag, ".readData"}, Read_data, expRD);
    @(negedge clock);
    checkOutput({tag, ".donePulse"}, 32'(Mem_done), 32'd0);
    checkOutput({tag, ".errClear"},  32'({Addr_error, Bus_error}), 32'd0);
    checkOutput({tag, ".rdHeld"},    Read_data, expRD);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, req;
    logic ae, be, rd, wr;
    logic [31:0] addr;
    int ackDelay;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1, 2, 1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 32'h5555_5555, 3, 4, 3, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h7777_7777, 1, 1, 0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h9999_9999, 0, 5, 4, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 32'h1111_1111, 2, 3, 2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hA5A5_A5A5, 4, 5, 4, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0F0F_0F0F, 32'h2222_2222, 1, 1, 0, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 2, 3, 2, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D};

    reset         = 1'b0;
    Mem_read      = 1'b0;
    Mem_write     = 1'b0;
    ALU_Result    = '0;
    Read_data_2   = '0;
    bus.Mem_ack   = 1'b0;
    bus.Mem_rdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst.req",      32'(bus.Mem_req), 32'd0);
    checkOutput("rst.we",       32'(bus.Mem_we), 32'd0);
    checkOutput("rst.addr",     bus.Mem_addr, 32'd0);
    checkOutput("rst.wdata",    bus.Mem_wdata, 32'd0);
    checkOutput("rst.readData", Read_data, 32'd0);
    checkOutput("rst.flags",    32'({Mem_done, Addr_error, Bus_error, Mem_stall}), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].ackDelay, vecs[i].expLat, vecs[i].expReq,
                    vecs[i].expWe, vecs[i].expAE, vecs[i].expBE, vecs[i].expRD);
    end
    modelRD = vecs[7].expRD;

    // Timeout followed by a late ack while idle
    applyStimulus("lateAck", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h3333_3333, 0,
                  TIMEOUT + 1, TIMEOUT, 1'b0, 1'b0, 1'b1, modelRD);
    bus.Mem_ack   = 1'b1;
    bus.Mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.Mem_ack = 1'b0;
    @(negedge clock);
    checkOutput("lateAck.noReq",  32'(bus.Mem_req), 32'd0);
    checkOutput("lateAck.noDone", 32'(Mem_done), 32'd0);
    checkOutput("lateAck.rdKept", Read_data, modelRD);

    // Reset asserted in the middle of a request
    @(negedge clock);
    Mem_read   = 1'b1;
    ALU_Result = 32'h0000_0100;
    @(negedge clock);
    checkOutput("midRst.reqUp", 32'(bus.Mem_req), 32'd1);
    @(negedge clock);
    reset    = 1'b0;
    Mem_read = 1'b0;
    @(negedge clock);
    checkOutput("midRst.req",      32'(bus.Mem_req), 32'd0);
    checkOutput("midRst.done",     32'(Mem_done), 32'd0);
    checkOutput("midRst.addr",     bus.Mem_addr, 32'd0);
    checkOutput("midRst.readData", Read_data, 32'd0);
    checkOutput("midRst.stall",    32'(Mem_stall), 32'd0);
    reset       = 1'b1;
    bus.Mem_ack = 1'b1;
    bus.Mem_rdata = 32'hEEEE_EEEE;
    @(negedge clock);
    bus.Mem_ack = 1'b0;
    checkOutput("midRst.lateDone", 32'(Mem_done), 32'd0);
    checkOutput("midRst.lateRd",   Read_data, 32'd0);
    modelRD = 32'd0;
    modelTxn(1'b0, 32'h0000_0104, 32'h4444_4444, 1, lat, req, ae, be);
    applyStimulus("postRst", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h4444_4444, 1,
                  lat, req, 1'b0, ae, be, modelRD);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] wdata, rdata;
      int op;
      op       = $urandom_range(0, 2);
      rd       = (op != 1);
      wr       = (op != 0);
      addr     = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata    = $urandom();
      rdata    = $urandom();
      ackDelay = $urandom_range(0, TIMEOUT + 1);
      modelTxn(wr, addr, rdata, ackDelay, lat, req, ae, be);
      applyStimulus($sformatf("rnd%0d", n), rd, wr, addr, wdata, rdata, ackDelay,
                    lat, req, wr, ae, be, modelRD);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memio_access.md
Name: memio_access

Overview:
- Memory-access stage directly downstream of the 32-bit execute unit.
- Consumes the ALU result as a byte address and rt as store data.
- Runs lw/sw transactions over a req/ack data-memory bus and returns load data to write-back.
- Holds Mem_stall high while a transaction is outstanding so fetch/decode freeze.

Parameters:
- TIMEOUT, 16, max cycles to wait for Mem_ack before aborting (legal range 1..255).
- ADDR_W, 32, width of the byte address driven on the bus.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- Mem_read  input  1  from control; 1 = lw this instruction.
- Mem_write  input  1  from control; 1 = sw this instruction.
- ALU_Result  input  32  from execute; effective byte address.
- Read_data_2  input  32  from decode; store data (rt).
- Mem_req  output  1  bus request.
- Mem_we  output  1  bus write enable; valid while Mem_req=1.
- Mem_addr  output  ADDR_W  bus word-aligned byte address.
- Mem_wdata  output  32  bus write data.
- Mem_rdata  input  32  bus read data; valid when Mem_ack=1.
- Mem_ack  input  1  bus acknowledge; one-cycle pulse.
- Read_data  output  32  load result to write-back; held until next completed load.
- Mem_stall  output  1  1 = freeze PC and upstream registers.
- Mem_done  output  1  one-cycle pulse: access finished (ok or error).
- Addr_error  output  1  one-cycle pulse with Mem_done: misaligned address.
- Bus_error  output  1  one-cycle pulse with Mem_done: ack timeout.

Behaviour:
- Reset (reset=0 at clock edge): state=IDLE.
  - Mem_req, Mem_we, Mem_done, Addr_error, Bus_error = 0.
  - Mem_addr, Mem_wdata, Read_data = 0; timeout counter = 0.
  - Applies mid-transaction: request dropped immediately, no Mem_done; a late Mem_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - Mem_write=1 (priority over Mem_read if both high; read discarded):
    - ALU_Result[1:0]!=0 -> DONE with Addr_error.
    - Else -> REQ; latch Mem_addr=ALU_Result, Mem_wdata=Read_data_2, Mem_we=1.
  - Mem_read=1 only: same, with Mem_we=0.
  - Neither: stay IDLE.
  - Mem_ack seen in IDLE is ignored.
- REQ:
  - Mem_req=1.
  - Mem_addr/Mem_we/Mem_wdata stay stable until ack.
  - Counter increments each cycle.
  - Mem_ack=1: load captures Mem_rdata into Read_data; go to DONE (ok).
  - Counter reaches TIMEOUT with no ack: go to DONE with Bus_error; Read_data unchanged.
  - Ack in the same cycle the counter expires counts as success.
- DONE:
  - Mem_done=1 for exactly one cycle, plus Addr_error or Bus_error if flagged.
  - Mem_req=0; counter cleared; return to IDLE.
  - A new request is not accepted in DONE; control re-presents it after the stall drops.
- Mem_stall (combinational):
  - 1 in IDLE when (Mem_read|Mem_write).
  - 1 throughout REQ.
  - 0 in DONE, so the pipeline advances on the Mem_done cycle.
- Latency:
  - Ack in the first REQ cycle -> Mem_done 2 cycles after the request is seen in IDLE.
  - Misaligned -> Mem_done 1 cycle after.
  - Timeout -> Mem_done TIMEOUT+1 cycles after.
- Read_data changes only on a successful load; stores and errors leave it unchanged.
- Mem_addr is the full 32-bit byte address (bits [1:0] always 0 when Mem_req=1); no wrap logic, 0xFFFFFFFC is legal.

Test Plan:
- Load, ack 1 cycle into REQ:
  - Mem_read=1, ALU_Result=0x00000010, Mem_rdata=0xDEADBEEF.
  - Expect: Mem_req high 1 cycle, Mem_we=0; Read_data=0xDEADBEEF; Mem_done pulse at cycle 2; Mem_stall 0 on that cycle.
- Store, ack after 3 cycles:
  - Mem_write=1, ALU_Result=0x00000024, Read_data_2=0x12345678.
  - Expect: Mem_addr=0x24, Mem_wdata=0x12345678, Mem_we=1, all stable 3 cycles; Mem_done after ack; Read_data unchanged.
- Misaligned load:
  - ALU_Result=0x00000013.
  - Expect: no Mem_req; Mem_done+Addr_error 1 cycle later; Read_data unchanged.
- Timeout with TIMEOUT=4 and no ack:
  - Expect: Mem_req high 4 cycles, then Mem_done+Bus_error; a late ack next cycle is ignored.
- Mem_read=Mem_write=1:
  - Expect: write performed (Mem_we=1), no load, Read_data unchanged.
- reset=0 during REQ:
  - Expect: next edge all outputs 0, state IDLE, no Mem_done; a following load completes normally.
